mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage access controller; sits between the MEM pipeline stage and its two targets: the CLINT timer register port and the main data bus.
- Accepts one load/store per MEM instruction and checks alignment.
- Decodes the target, drives that target's valid/ready handshake, then aligns and extends load data.
- Holds the pipeline via a stall signal until the access completes.

Parameters:
- CLINT_BASE, 64'h0000_0000_0200_0000: base of the CLINT window.
- CLINT_SIZE, 64'h0000_0000_0001_0000: size of the CLINT window in bytes.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- mem_valid_i  in  1  MEM stage holds a load/store.
- mem_req_i  in  1  `REQ_READ / `REQ_WRITE.
- mem_addr_i  in  64  byte address.
- mem_size_i  in  2  00 byte, 01 half, 10 word, 11 double.
- mem_unsigned_i  in  1  zero-extend load.
- mem_wdata_i  in  64  store data, LSB-justified.
- mem_stall_o  out  1  hold pipeline.
- mem_done_o  out  1  access complete, one-cycle pulse.
- mem_rdata_o  out  64  extended load data.
- mem_err_o  out  1  misaligned or bus error; valid with done.
- clint_valid_o  out  1  CLINT request valid.
- clint_req_o  out  1  CLINT request type.
- clint_addr_o  out  64  CLINT address.
- clint_size_o  out  2  CLINT access size.
- clint_data_write_o  out  64  CLINT write data.
- clint_ready_i  in  1  CLINT ready.
- clint_data_read_i  in  64  CLINT read data.
- clint_resp_i  in  2  CLINT response.
- dbus_valid_o  out  1  data-bus request valid.
- dbus_req_o  out  1  data-bus request type.
- dbus_addr_o  out  64  data-bus address.
- dbus_size_o  out  2  data-bus access size.
- dbus_wdata_o  out  64  lane-shifted write data.
- dbus_wstrb_o  out  8  byte strobes.
- dbus_ready_i  in  1  data-bus ready.
- dbus_rdata_i  in  64  data-bus read data.
- dbus_resp_i  in  2  data-bus response.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset state: FSM goes to IDLE. All *_valid_o, mem_done_o, mem_err_o and mem_stall_o = 0. mem_rdata_o = 0. Latched request registers = 0.
- FSM states: IDLE, CLINT, DBUS, DONE.
- IDLE, on mem_valid_i: latch req/addr/size/unsigned/wdata.
  - Misaligned (addr not a multiple of 2^size): go to DONE with err=1; no bus traffic.
  - Hit = CLINT_BASE <= addr < CLINT_BASE+CLINT_SIZE. Hit with size != 11: DONE with err=1.
  - Hit otherwise: go to CLINT. Miss: go to DBUS.
- CLINT / DBUS states: assert the target's valid with latched fields, held stable until ready.
  - On ready: capture read data; err = (resp != 2'b00); go to DONE.
  - Valid deasserts in the cycle after the handshake.
- DONE: mem_done_o=1 and mem_rdata_o/mem_err_o valid for exactly this cycle. Next state IDLE.
- mem_stall_o = mem_valid_i & (state != DONE).
  - The pipeline advances at the DONE cycle; the next request is sampled in the following IDLE cycle.
- Latency: CLINT (ready tied 1) gives accept, handshake, DONE → done on the 3rd cycle of mem_valid_i. Data bus: 2 + ready wait cycles.
- CLINT path: data and address passed unshifted (64-bit registers only).
- Data-bus store: wdata shifted left by addr[2:0]*8. Strobes: B 8'h01, H 8'h03, W 8'h0F, D 8'hFF, each shifted left by addr[2:0]. dbus_addr_o = full byte address.
- Load extraction: shift read data right by addr[2:0]*8, truncate to size, then sign- or zero-extend per unsigned. Size 11 is never extended.
- Stores: mem_rdata_o = 0.
- Error: mem_rdata_o = 0 when err=1.
- Reset mid-operation: request dropped; valid outputs low the cycle after rst is sampled; no done pulse.
- mem_valid_i falling during CLINT/DBUS (flush): the in-flight handshake still completes; the DONE pulse is still produced.

Decomposition:
- Shared defines.v: `REQ_READ/`REQ_WRITE, `SIZE_B/H/W/D encodings, `DATA_BUS, `DATA_ADDR_BUS, `MTIME_ADDR, `MTIMECMP_ADDR, CLINT base/size defaults, FSM state encodings.
- One combinational sub-module, mem_lane_align: store shift and strobe generation, load extract and extend. Keeps the FSM module free of datapath.

Test Plan:
- Store 64'h1234 (size 11, write) to 64'h0200_4000 with clint_ready_i=1 → clint_valid_o high for 1 cycle carrying addr 64'h0200_4000 and data 64'h1234; done on 3rd cycle, err=0, stall high for the first 2 cycles.
- Load byte (size 00, signed) from 64'h8000_0003, data-bus ready after 4 cycles, rdata 64'h0000_0000_8000_0000 → mem_rdata_o = 64'hFFFF_FFFF_FFFF_FF80; dbus_valid_o held and stable for all 4 wait cycles.
- Store half 16'hBEEF to 64'h8000_0006 → dbus_wstrb_o = 8'hC0, dbus_wdata_o[63:48] = 16'hBEEF.
- Load word from 64'h8000_0002 → done on 2nd cycle, err=1, no valid on either bus.
- Load word from 64'h0200_BFF8 → err=1 (CLINT non-double). Then load double from the same address with dbus_resp_i irrelevant and clint_resp_i=2'b10 → err=1, rdata 0.
- rst asserted in a DBUS wait cycle → dbus_valid_o=0 and state IDLE next cycle, no done pulse. A following CLINT load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// mem_access_ctrl_pkg: shared encodings, FSM states and the alignment helper for the memory-stage controller
package mem_access_ctrl_pkg;
    localparam int DATA_BUS = 64;
    localparam int DATA_ADDR_BUS = 64;
    localparam logic REQ_READ = 1'b0;
    localparam logic REQ_WRITE = 1'b1;
    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;
    localparam logic [63:0] CLINT_BASE_DEF = 64'h0000_0000_0200_0000;
    localparam logic [63:0] CLINT_SIZE_DEF = 64'h0000_0000_0001_0000;

    typedef enum logic [1:0] {IDLE, CLINT, DBUS, DONE} state_t;

    function automatic logic misaligned(input logic [2:0] off, input logic [1:0] size);
        return size == SIZE_H ? off[0] : size == SIZE_W ? |off[1:0] : size == SIZE_D ? |off : 1'b0;
    endfunction
endpackage

// File: rtl/mem_lane_align.sv
// mem_lane_align: store lane shift and strobes, load extraction and sign/zero extension
module mem_lane_align
    import mem_access_ctrl_pkg::*;
(
    input  logic [2:0]          off,
    input  logic [1:0]          size,
    input  logic                uns,
    input  logic [DATA_BUS-1:0] wdata,
    input  logic [DATA_BUS-1:0] rdata,
    output logic [DATA_BUS-1:0] wdata_sh,
    output logic [7:0]          wstrb,
    output logic [DATA_BUS-1:0] rdata_ext
);
    logic [5:0]          sh;
    logic [7:0]          base;
    logic [DATA_BUS-1:0] r;

    always_comb begin
        sh = {off, 3'b000};
        base = size == SIZE_B ? 8'h01 : size == SIZE_H ? 8'h03 : size == SIZE_W ? 8'h0F : 8'hFF;
        wstrb = base << off;
        wdata_sh = wdata << sh;
        r = rdata >> sh;
        rdata_ext = size == SIZE_B ? {{56{~uns & r[7]}}, r[7:0]} :
                    size == SIZE_H ? {{48{~uns & r[15]}}, r[15:0]} :
                    size == SIZE_W ? {{32{~uns & r[31]}}, r[31:0]} : r;
    end
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MEM-stage load/store controller routing accesses to the CLINT port or the data bus
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter logic [63:0] CLINT_BASE = CLINT_BASE_DEF,
    parameter logic [63:0] CLINT_SIZE = CLINT_SIZE_DEF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mem_valid_i,
    input  logic                     mem_req_i,
    input  logic [DATA_ADDR_BUS-1:0] mem_addr_i,
    input  logic [1:0]               mem_size_i,
    input  logic                     mem_unsigned_i,
    input  logic [DATA_BUS-1:0]      mem_wdata_i,
    output logic                     mem_stall_o,
    output logic                     mem_done_o,
    output logic [DATA_BUS-1:0]      mem_rdata_o,
    output logic                     mem_err_o,
    output logic                     clint_valid_o,
    output logic                     clint_req_o,
    output logic [DATA_ADDR_BUS-1:0] clint_addr_o,
    output logic [1:0]               clint_size_o,
    output logic [DATA_BUS-1:0]      clint_data_write_o,
    input  logic                     clint_ready_i,
    input  logic [DATA_BUS-1:0]      clint_data_read_i,
    input  logic [1:0]               clint_resp_i,
    output logic                     dbus_valid_o,
    output logic                     dbus_req_o,
    output logic [DATA_ADDR_BUS-1:0] dbus_addr_o,
    output logic [1:0]               dbus_size_o,
    output logic [DATA_BUS-1:0]      dbus_wdata_o,
    output logic [7:0]               dbus_wstrb_o,
    input  logic                     dbus_ready_i,
    input  logic [DATA_BUS-1:0]      dbus_rdata_i,
    input  logic [1:0]               dbus_resp_i
);
    state_t                   state, next;
    logic                     req_q, uns_q, err_q;
    logic [DATA_ADDR_BUS-1:0] addr_q;
    logic [1:0]               size_q;
    logic [DATA_BUS-1:0]      wdata_q, rdata_q, rdata_ext;
    logic                     hit, bad;

    mem_lane_align u_align (
        .off      (addr_q[2:0]),
        .size     (size_q),
        .uns      (uns_q),
        .wdata    (wdata_q),
        .rdata    (rdata_q),
        .wdata_sh (dbus_wdata_o),
        .wstrb    (dbus_wstrb_o),
        .rdata_ext(rdata_ext)
    );

    // CLINT registers are 64-bit only, so any narrower access in the window is rejected up front
    assign hit = mem_addr_i >= CLINT_BASE && mem_addr_i < CLINT_BASE + CLINT_SIZE;
    assign bad = misaligned(mem_addr_i[2:0], mem_size_i) || (hit && mem_size_i != SIZE_D);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= next;
    end

    always_comb begin
        next = state;
        case (state)
            IDLE:  if (mem_valid_i) next = bad ? DONE : hit ? CLINT : DBUS;
            CLINT: if (clint_ready_i) next = DONE;
            DBUS:  if (dbus_ready_i) next = DONE;
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= 1'b0;
            addr_q <= '0;
            size_q <= '0;
            uns_q <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q <= 1'b0;
        end else begin
            if (state == IDLE && mem_valid_i) begin
                req_q <= mem_req_i;
                addr_q <= mem_addr_i;
                size_q <= mem_size_i;
                uns_q <= mem_unsigned_i;
                wdata_q <= mem_wdata_i;
                err_q <= bad;
            end
            if (state == CLINT && clint_ready_i) begin
                rdata_q <= clint_data_read_i;
                err_q <= |clint_resp_i;
            end
            if (state == DBUS && dbus_ready_i) begin
                rdata_q <= dbus_rdata_i;
                err_q <= |dbus_resp_i;
            end
        end
    end

    assign mem_stall_o = mem_valid_i && state != DONE;
    assign mem_done_o = state == DONE;
    assign mem_err_o = mem_done_o && err_q;
    assign mem_rdata_o = mem_done_o && !err_q && req_q == REQ_READ ? rdata_ext : '0;
    assign clint_valid_o = state == CLINT;
    assign clint_req_o = req_q;
    assign clint_addr_o = addr_q;
    assign clint_size_o = size_q;
    assign clint_data_write_o = wdata_q;
    assign dbus_valid_o = state == DBUS;
    assign dbus_req_o = req_q;
    assign dbus_addr_o = addr_q;
    assign dbus_size_o = size_q;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: directed self-checking bench for mem_access_ctrl
module tb_mem_access_ctrl;
    logic        clk = 1'b0, rst = 1'b1;
    logic        mem_valid_i = 1'b0, mem_req_i = 1'b0, mem_unsigned_i = 1'b0;
    logic [63:0] mem_addr_i = '0, mem_wdata_i = '0;
    logic [1:0]  mem_size_i = '0;
    logic        mem_stall_o, mem_done_o, mem_err_o;
    logic [63:0] mem_rdata_o;
    logic        clint_valid_o, clint_req_o;
    logic [63:0] clint_addr_o, clint_data_write_o;
    logic [1:0]  clint_size_o;
    logic        clint_ready_i = 1'b0;
    logic [63:0] clint_data_read_i = '0;
    logic [1:0]  clint_resp_i = '0;
    logic        dbus_valid_o, dbus_req_o;
    logic [63:0] dbus_addr_o, dbus_wdata_o;
    logic [1:0]  dbus_size_o;
    logic [7:0]  dbus_wstrb_o;
    logic        dbus_ready_i = 1'b0;
    logic [63:0] dbus_rdata_i = '0;
    logic [1:0]  dbus_resp_i = '0;
    int errors = 0, checks = 0;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .mem_valid_i(mem_valid_i), .mem_req_i(mem_req_i), .mem_addr_i(mem_addr_i),
        .mem_size_i(mem_size_i), .mem_unsigned_i(mem_unsigned_i), .mem_wdata_i(mem_wdata_i),
        .mem_stall_o(mem_stall_o), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o), .mem_err_o(mem_err_o),
        .clint_valid_o(clint_valid_o), .clint_req_o(clint_req_o), .clint_addr_o(clint_addr_o),
        .clint_size_o(clint_size_o), .clint_data_write_o(clint_data_write_o), .clint_ready_i(clint_ready_i),
        .clint_data_read_i(clint_data_read_i), .clint_resp_i(clint_resp_i),
        .dbus_valid_o(dbus_valid_o), .dbus_req_o(dbus_req_o), .dbus_addr_o(dbus_addr_o),
        .dbus_size_o(dbus_size_o), .dbus_wdata_o(dbus_wdata_o), .dbus_wstrb_o(dbus_wstrb_o),
        .dbus_ready_i(dbus_ready_i), .dbus_rdata_i(dbus_rdata_i), .dbus_resp_i(dbus_resp_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic rq, input logic [63:0] a, input logic [1:0] s, input logic u, input logic [63:0] wd);
        mem_valid_i = 1'b1;
        mem_req_i = rq;
        mem_addr_i = a;
        mem_size_i = s;
        mem_unsigned_i = u;
        mem_wdata_i = wd;
        #1;
    endtask

    task automatic drop();
        mem_valid_i = 1'b0;
        #1;
    endtask

    initial begin
        tick();
        tick();
        #1;
        chk("rst_stall", mem_stall_o, 0);
        chk("rst_done", mem_done_o, 0);
        chk("rst_clint_valid", clint_valid_o, 0);
        chk("rst_dbus_valid", dbus_valid_o, 0);
        chk("rst_rdata", mem_rdata_o, 0);
        chk("rst_err", mem_err_o, 0);
        rst = 1'b0;

        // CLINT store, ready tied high
        tick();
        clint_ready_i = 1'b1;
        issue(1'b1, 64'h0200_4000, 2'b11, 1'b0, 64'h1234);
        chk("cs_c1_stall", mem_stall_o, 1);
        chk("cs_c1_cvalid", clint_valid_o, 0);
        tick(); #1;
        chk("cs_c2_cvalid", clint_valid_o, 1);
        chk("cs_c2_addr", clint_addr_o, 64'h0200_4000);
        chk("cs_c2_data", clint_data_write_o, 64'h1234);
        chk("cs_c2_req", clint_req_o, 1);
        chk("cs_c2_stall", mem_stall_o, 1);
        chk("cs_c2_dvalid", dbus_valid_o, 0);
        tick(); #1;
        chk("cs_c3_done", mem_done_o, 1);
        chk("cs_c3_err", mem_err_o, 0);
        chk("cs_c3_stall", mem_stall_o, 0);
        chk("cs_c3_cvalid", clint_valid_o, 0);
        chk("cs_c3_rdata", mem_rdata_o, 0);
        drop();
        tick(); #1;
        chk("cs_idle_done", mem_done_o, 0);

        // signed byte load from data bus with 4 wait cycles
        issue(1'b0, 64'h8000_0003, 2'b00, 1'b0, 64'h0);
        chk("lb_c1_dvalid", dbus_valid_o, 0);
        for (int i = 0; i < 4; i++) begin
            tick(); #1;
            chk($sformatf("lb_wait%0d_dvalid", i), dbus_valid_o, 1);
            chk($sformatf("lb_wait%0d_addr", i), dbus_addr_o, 64'h8000_0003);
            chk($sformatf("lb_wait%0d_size", i), dbus_size_o, 0);
            chk($sformatf("lb_wait%0d_stall", i), mem_stall_o, 1);
        end
        dbus_ready_i = 1'b1;
        dbus_rdata_i = 64'h0000_0000_8000_0000;
        #1;
        chk("lb_hs_req", dbus_req_o, 0);
        tick(); #1;
        chk("lb_done", mem_done_o, 1);
        chk("lb_rdata", mem_rdata_o, 64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_err", mem_err_o, 0);
        chk("lb_dvalid_after", dbus_valid_o, 0);
        drop();

        // half store to upper lane
        tick();
        issue(1'b1, 64'h8000_0006, 2'b01, 1'b0, 64'hBEEF);
        tick(); #1;
        chk("sh_dvalid", dbus_valid_o, 1);
        chk("sh_wstrb", dbus_wstrb_o, 8'hC0);
        chk("sh_wdata_hi", dbus_wdata_o[63:48], 16'hBEEF);
        chk("sh_req", dbus_req_o, 1);
        tick(); #1;
        chk("sh_done", mem_done_o, 1);
        chk("sh_rdata", mem_rdata_o, 0);
        chk("sh_err", mem_err_o, 0);
        drop();

        // misaligned word load
        tick();
        dbus_ready_i = 1'b0;
        issue(1'b0, 64'h8000_0002, 2'b10, 1'b0, 64'h0);
        tick(); #1;
        chk("mis_done", mem_done_o, 1);
        chk("mis_err", mem_err_o, 1);
        chk("mis_rdata", mem_rdata_o, 0);
        chk("mis_dvalid", dbus_valid_o, 0);
        chk("mis_cvalid", clint_valid_o, 0);
        drop();

        // CLINT non-double access
        tick();
        issue(1'b0, 64'h0200_BFF8, 2'b10, 1'b0, 64'h0);
        tick(); #1;
        chk("cw_done", mem_done_o, 1);
        chk("cw_err", mem_err_o, 1);
        chk("cw_cvalid", clint_valid_o, 0);
        drop();

        // CLINT double load with error response
        tick();
        clint_resp_i = 2'b10;
        clint_data_read_i = 64'h1111_2222_3333_4444;
        dbus_resp_i = 2'b11;
        issue(1'b0, 64'h0200_BFF8, 2'b11, 1'b0, 64'h0);
        tick(); #1;
        chk("ce_cvalid", clint_valid_o, 1);
        chk("ce_size", clint_size_o, 2'b11);
        tick(); #1;
        chk("ce_done", mem_done_o, 1);
        chk("ce_err", mem_err_o, 1);
        chk("ce_rdata", mem_rdata_o, 0);
        drop();
        clint_resp_i = 2'b00;
        dbus_resp_i = 2'b00;

        // flush during data-bus wait: unsigned half load still completes
        tick();
        issue(1'b0, 64'h8000_0004, 2'b01, 1'b1, 64'h0);
        tick(); #1;
        chk("fl_dvalid", dbus_valid_o, 1);
        drop();
        dbus_ready_i = 1'b1;
        dbus_rdata_i = 64'h0000_F00D_0000_0000;
        #1;
        chk("fl_stall", mem_stall_o, 0);
        tick(); #1;
        chk("fl_done", mem_done_o, 1);
        chk("fl_rdata", mem_rdata_o, 64'h0000_0000_0000_F00D);
        dbus_ready_i = 1'b0;

        // reset during data-bus wait
        tick();
        issue(1'b0, 64'h8000_0008, 2'b11, 1'b0, 64'h0);
        tick(); #1;
        chk("rm_dvalid_pre", dbus_valid_o, 1);
        rst = 1'b1;
        tick(); #1;
        chk("rm_dvalid_post", dbus_valid_o, 0);
        chk("rm_done_post", mem_done_o, 0);
        rst = 1'b0;
        drop();
        tick(); #1;
        chk("rm_done_idle", mem_done_o, 0);
        chk("rm_dvalid_idle", dbus_valid_o, 0);

        // CLINT load after reset
        clint_data_read_i = 64'hDEAD_BEEF_0123_4567;
        issue(1'b0, 64'h0200_0000, 2'b11, 1'b0, 64'h0);
        tick(); #1;
        chk("cl_cvalid", clint_valid_o, 1);
        chk("cl_addr", clint_addr_o, 64'h0200_0000);
        tick(); #1;
        chk("cl_done", mem_done_o, 1);
        chk("cl_err", mem_err_o, 0);
        chk("cl_rdata", mem_rdata_o, 64'hDEAD_BEEF_0123_4567);
        drop();
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
